// File: rtl/game_pkg.sv
// Shared constants and types for the fret-button front end.
package game_pkg;
  localparam int N_BUTTONS_DEF = 2;
  localparam int DEBOUNCE_W    = 16;

  typedef logic [N_BUTTONS_DEF-1:0] btn_vec_t;
endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, edge pulses and
// a saturating press counter.
module debounce_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             raw,
  input  logic             enable,
  input  logic             clear_counts,
  output logic             held,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam logic [DEBOUNCE_W-1:0] DCNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

  logic                  sync1;
  logic                  sync2;
  logic                  stbl;
  logic                  stbl_next;
  logic [DEBOUNCE_W-1:0] dcnt;
  logic [DEBOUNCE_W-1:0] dcnt_next;
  logic                  accept_press;
  logic                  accept_release;

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    stbl_next = stbl;
    dcnt_next = dcnt + DEBOUNCE_W'(1);
    if (sync2 == stbl) begin
      dcnt_next = '0;
    end else if (dcnt == DCNT_LAST) begin
      stbl_next = sync2;
      dcnt_next = '0;
    end
  end

  assign accept_press   = enable & ~stbl & stbl_next;
  assign accept_release = enable & stbl & ~stbl_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stbl          <= 1'b0;
      dcnt          <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      stbl          <= stbl_next;
      dcnt          <= dcnt_next;
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      // Clear first, then a same-edge press still counts as one.
      if (clear_counts) begin
        press_count <= accept_press ? CNT_W'(1) : '0;
      end else if (accept_press && (press_count != CNT_MAX)) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

  assign held = stbl;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw fret-button pins into debounced levels, edge pulses and
// per-channel press counts for main_game.
module button_conditioner
  import game_pkg::*;
#(
  parameter int N_BUTTONS       = N_BUTTONS_DEF,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [N_BUTTONS-1:0]       raw_btn,
  input  logic                       enable,
  input  logic                       clear_counts,
  output logic [N_BUTTONS-1:0]       btn_held,
  output logic [N_BUTTONS-1:0]       press_pulse,
  output logic [N_BUTTONS-1:0]       release_pulse,
  output logic [N_BUTTONS*CNT_W-1:0] press_count
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk           (clk),
      .n_rst         (n_rst),
      .raw           (raw_btn[i]),
      .enable        (enable),
      .clear_counts  (clear_counts),
      .held          (btn_held[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .press_count   (press_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner with a 4-sample debounce window.
module tb_button_conditioner;
  import game_pkg::*;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [NB-1:0]    held;
    logic [NB-1:0]    pp;
    logic [NB-1:0]    rp;
    logic [NB*CW-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             n_rst;
  btn_vec_t         raw_btn;
  logic             enable;
  logic             clear_counts;
  logic [NB-1:0]    btn_held;
  logic [NB-1:0]    press_pulse;
  logic [NB-1:0]    release_pulse;
  logic [NB*CW-1:0] press_count;

  int n_vec = 0;
  int n_err = 0;
  int rel1_cnt = 0;
  int rel_start;

  exp_t exp_q[$];

  button_conditioner #(
    .N_BUTTONS       (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .raw_btn       (raw_btn),
    .enable        (enable),
    .clear_counts  (clear_counts),
    .btn_held      (btn_held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: synchronizer pipe, run length of disagreeing samples.
  logic [NB-1:0] m_s1, m_s2, m_st;
  int            m_run [NB];
  logic [CW-1:0] m_cnt [NB];
  logic [NB-1:0] n_st, n_pp, n_rp;
  int            n_run [NB];
  logic [CW-1:0] n_cnt [NB];
  exp_t          n_exp;

  always_comb begin
    n_st  = m_st;
    n_pp  = '0;
    n_rp  = '0;
    n_exp = '0;
    for (int i = 0; i < NB; i++) begin
      n_run[i] = 0;
      n_cnt[i] = m_cnt[i];
      if (m_s2[i] != m_st[i]) begin
        if (m_run[i] + 1 >= DC) n_st[i] = m_s2[i];
        else n_run[i] = m_run[i] + 1;
      end
      n_pp[i] = enable && !m_st[i] && n_st[i];
      n_rp[i] = enable && m_st[i] && !n_st[i];
      if (clear_counts) n_cnt[i] = n_pp[i] ? CW'(1) : '0;
      else if (n_pp[i] && m_cnt[i] < CW'(255)) n_cnt[i] = m_cnt[i] + CW'(1);
      n_exp.cnt[i*CW +: CW] = n_cnt[i];
    end
    n_exp.held = n_st;
    n_exp.pp   = n_pp;
    n_exp.rp   = n_rp;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_s1 <= '0;
      m_s2 <= '0;
      m_st <= '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] <= 0;
        m_cnt[i] <= '0;
      end
      exp_q.delete();
    end else begin
      m_s1 <= raw_btn;
      m_s2 <= m_s1;
      m_st <= n_st;
      m_run <= n_run;
      m_cnt <= n_cnt;
      exp_q.push_back(n_exp);
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk("sb_held", 32'(btn_held), 32'(exp_q[0].held));
      chk("sb_press", 32'(press_pulse), 32'(exp_q[0].pp));
      chk("sb_release", 32'(release_pulse), 32'(exp_q[0].rp));
      chk("sb_count", 32'(press_count), 32'(exp_q[0].cnt));
      chk("sb_excl", 32'(press_pulse & release_pulse), 32'd0);
      void'(exp_q.pop_front());
    end
    if (n_rst && release_pulse[1]) rel1_cnt <= rel1_cnt + 1;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_held"}, 32'(btn_held), 32'd0);
    chk({tag, "_pp"}, 32'(press_pulse), 32'd0);
    chk({tag, "_rp"}, 32'(release_pulse), 32'd0);
    chk({tag, "_cnt"}, 32'(press_count), 32'd0);
  endtask

  logic [7:0] pat;

  initial begin
    n_rst = 1'b0;
    raw_btn = '0;
    enable = 1'b1;
    clear_counts = 1'b0;
    pat = 8'b1011_0110;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press on channel 0: accepted on the 6th edge.
    raw_btn = 2'b01;
    repeat (5) @(posedge clk);
    #1 chk("t1_held_e5", 32'(btn_held[0]), 32'd0);
    @(posedge clk);
    #1 chk("t1_held_e6", 32'(btn_held[0]), 32'd1);
    chk("t1_pp_e6", 32'(press_pulse[0]), 32'd1);
    chk("t1_ch1", 32'(btn_held[1]), 32'd0);
    @(posedge clk);
    #1 chk("t1_pp_e7", 32'(press_pulse[0]), 32'd0);
    chk("t1_cnt", 32'(press_count[0 +: CW]), 32'd1);
    repeat (6) @(negedge clk);
    raw_btn = '0;
    repeat (12) @(negedge clk);
    chk("t1_released", 32'(btn_held), 32'd0);

    // 3-sample glitch is rejected.
    raw_btn = 2'b01;
    repeat (3) @(negedge clk);
    raw_btn = '0;
    repeat (12) @(negedge clk);
    chk("t2_held", 32'(btn_held), 32'd0);
    chk("t2_cnt", 32'(press_count), 32'h0001);

    // Chatter on both channels never reaches 4 stable samples.
    for (int r = 0; r < 3; r++) begin
      for (int j = 7; j >= 0; j--) begin
        raw_btn = {NB{pat[j]}};
        @(negedge clk);
      end
    end
    raw_btn = '0;
    repeat (12) @(negedge clk);
    chk("t3_cnt", 32'(press_count), 32'h0001);

    // 260 presses on channel 1: counter saturates, every release pulses.
    rel_start = rel1_cnt;
    for (int k = 0; k < 260; k++) begin
      raw_btn = 2'b10;
      repeat (8) @(negedge clk);
      raw_btn = '0;
      repeat (8) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("t4_sat", 32'(press_count[CW +: CW]), 32'd255);
    chk("t4_releases", 32'(rel1_cnt - rel_start), 32'd260);

    // Level tracks with enable low; no pulse, no count.
    enable = 1'b0;
    raw_btn = 2'b01;
    repeat (10) @(negedge clk);
    chk("t5_held_dis", 32'(btn_held[0]), 32'd1);
    chk("t5_cnt_dis", 32'(press_count[0 +: CW]), 32'd1);
    raw_btn = '0;
    repeat (10) @(negedge clk);
    chk("t5_rel_dis", 32'(btn_held[0]), 32'd0);
    enable = 1'b1;
    raw_btn = 2'b01;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear_counts = 1'b1;
    @(posedge clk);
    #1 chk("t5_clr_press", 32'(press_count[0 +: CW]), 32'd1);
    chk("t5_clr_ch1", 32'(press_count[CW +: CW]), 32'd0);
    chk("t5_clr_pp", 32'(press_pulse[0]), 32'd1);
    @(negedge clk);
    clear_counts = 1'b0;
    raw_btn = '0;
    repeat (12) @(negedge clk);

    // Async reset mid-debounce, then again while held.
    raw_btn = 2'b01;
    repeat (4) @(posedge clk);
    #2 n_rst = 1'b0;
    #1 chk_all_zero("t6_mid");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t6_held_e5", 32'(btn_held[0]), 32'd0);
    @(posedge clk);
    #1 chk("t6_held_e6", 32'(btn_held[0]), 32'd1);
    chk("t6_pp_e6", 32'(press_pulse[0]), 32'd1);
    chk("t6_cnt", 32'(press_count), 32'h0001);
    @(posedge clk);
    #1 chk("t6_pp_e7", 32'(press_pulse[0]), 32'd0);
    #2 n_rst = 1'b0;
    #1 chk_all_zero("t6_held_rst");
    @(negedge clk);
    n_rst = 1'b1;
    raw_btn = '0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
